// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between two requesters.
// Each op runs IDLE -> EXEC -> RESP and returns its result tagged with the requester id.
module alu_arbiter #(
  parameter int W  = 8,
  parameter int NW = 3,
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req0_valid,
  output logic          req0_ready,
  input  logic [W-1:0]  req0_a,
  input  logic [W-1:0]  req0_b,
  input  logic [2:0]    req0_op,
  input  logic [NW-1:0] req0_n,
  input  logic          req1_valid,
  output logic          req1_ready,
  input  logic [W-1:0]  req1_a,
  input  logic [W-1:0]  req1_b,
  input  logic [2:0]    req1_op,
  input  logic [NW-1:0] req1_n,
  output logic [W-1:0]  alu_a,
  output logic [W-1:0]  alu_b,
  output logic [2:0]    alu_s,
  output logic [NW-1:0] alu_n,
  output logic          alu_si,
  input  logic [W-1:0]  alu_w,
  input  logic          alu_co,
  input  logic          alu_ov,
  input  logic          alu_zero,
  input  logic          alu_neg,
  input  logic          alu_gt,
  input  logic          alu_eq,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic          rsp_id,
  output logic [W-1:0]  rsp_w,
  output logic [5:0]    rsp_flags,
  output logic [CW-1:0] cnt0,
  output logic [CW-1:0] cnt1
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t          state_r;
  logic            last_id_r;
  logic            id_r;
  logic [W-1:0]    op_a_r;
  logic [W-1:0]    op_b_r;
  logic [2:0]      op_s_r;
  logic [NW-1:0]   op_n_r;
  logic            rsp_valid_r;
  logic            rsp_id_r;
  logic [W-1:0]    rsp_w_r;
  logic [5:0]      rsp_flags_r;
  logic [CW-1:0]   cnt0_r;
  logic [CW-1:0]   cnt1_r;
  logic            gnt0_s;
  logic            gnt1_s;

  localparam logic [CW-1:0] CNT_ONE = {{(CW-1){1'b0}}, 1'b1};

  // Grant decode: on a tie the requester that did not win last time goes next.
  always_comb begin
    gnt0_s = 1'b0;
    gnt1_s = 1'b0;
    if (state_r == IDLE) begin
      if (req0_valid && req1_valid) begin
        gnt0_s = last_id_r;
        gnt1_s = ~last_id_r;
      end else begin
        gnt0_s = req0_valid;
        gnt1_s = req1_valid;
      end
    end else begin
      gnt0_s = 1'b0;
      gnt1_s = 1'b0;
    end
  end

  assign req0_ready = gnt0_s;
  assign req1_ready = gnt1_s;

  assign alu_a  = op_a_r;
  assign alu_b  = op_b_r;
  assign alu_s  = op_s_r;
  assign alu_n  = op_n_r;
  assign alu_si = 1'b0;

  assign rsp_valid = rsp_valid_r;
  assign rsp_id    = rsp_id_r;
  assign rsp_w     = rsp_w_r;
  assign rsp_flags = rsp_flags_r;
  assign cnt0      = cnt0_r;
  assign cnt1      = cnt1_r;

  // Sequencer: capture granted op, sample ALU after one cycle, hold response until taken.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      last_id_r   <= 1'b1;
      id_r        <= 1'b0;
      op_a_r      <= {W{1'b0}};
      op_b_r      <= {W{1'b0}};
      op_s_r      <= 3'd0;
      op_n_r      <= {NW{1'b0}};
      rsp_valid_r <= 1'b0;
      rsp_id_r    <= 1'b0;
      rsp_w_r     <= {W{1'b0}};
      rsp_flags_r <= 6'd0;
      cnt0_r      <= {CW{1'b0}};
      cnt1_r      <= {CW{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          if (gnt1_s) begin
            op_a_r    <= req1_a;
            op_b_r    <= req1_b;
            op_s_r    <= req1_op;
            op_n_r    <= req1_n;
            id_r      <= 1'b1;
            last_id_r <= 1'b1;
            state_r   <= EXEC;
          end else if (gnt0_s) begin
            op_a_r    <= req0_a;
            op_b_r    <= req0_b;
            op_s_r    <= req0_op;
            op_n_r    <= req0_n;
            id_r      <= 1'b0;
            last_id_r <= 1'b0;
            state_r   <= EXEC;
          end else begin
            state_r   <= IDLE;
          end
        end
        EXEC: begin
          rsp_w_r     <= alu_w;
          rsp_flags_r <= {alu_co, alu_ov, alu_zero, alu_neg, alu_gt, alu_eq};
          rsp_id_r    <= id_r;
          rsp_valid_r <= 1'b1;
          state_r     <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid_r <= 1'b0;
            if (rsp_id_r) begin
              cnt1_r <= cnt1_r + CNT_ONE;
            end else begin
              cnt0_r <= cnt0_r + CNT_ONE;
            end
            state_r <= IDLE;
          end else begin
            state_r <= RESP;
          end
        end
        default: begin
          rsp_valid_r <= 1'b0;
          state_r     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a behavioural ALU stub on the alu_* side.
// ALU stub ops: 0 add, 1 sub, 2 signed max, 3 or, 4 xor, 5 negate a, 6 a<<n, 7 and.
module tb_alu_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic       req0_valid, req0_ready, req1_valid, req1_ready;
  logic [7:0] req0_a, req0_b, req1_a, req1_b;
  logic [2:0] req0_op, req1_op, req0_n, req1_n;
  logic [7:0] alu_a, alu_b, alu_w;
  logic [2:0] alu_s, alu_n;
  logic       alu_si, alu_co, alu_ov, alu_zero, alu_neg, alu_gt, alu_eq;
  logic       rsp_valid, rsp_ready, rsp_id;
  logic [7:0] rsp_w;
  logic [5:0] rsp_flags;
  logic [7:0] cnt0, cnt1;

  int vectors = 0;
  int errors  = 0;

  always #5 clk = ~clk;

  alu_arbiter #(.W(8), .NW(3), .CW(8)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
    .req0_op(req0_op), .req0_n(req0_n),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
    .req1_op(req1_op), .req1_n(req1_n),
    .alu_a(alu_a), .alu_b(alu_b), .alu_s(alu_s), .alu_n(alu_n), .alu_si(alu_si),
    .alu_w(alu_w), .alu_co(alu_co), .alu_ov(alu_ov), .alu_zero(alu_zero),
    .alu_neg(alu_neg), .alu_gt(alu_gt), .alu_eq(alu_eq),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_w(rsp_w),
    .rsp_flags(rsp_flags), .cnt0(cnt0), .cnt1(cnt1)
  );

  // Behavioural ALU stub
  always_comb begin
    alu_co = 1'b0;
    alu_ov = 1'b0;
    case (alu_s)
      3'd0: begin
        {alu_co, alu_w} = {1'b0, alu_a} + {1'b0, alu_b};
        alu_ov = (alu_a[7] == alu_b[7]) && (alu_w[7] != alu_a[7]);
      end
      3'd1: begin
        {alu_co, alu_w} = {1'b0, alu_a} - {1'b0, alu_b};
        alu_ov = (alu_a[7] != alu_b[7]) && (alu_w[7] != alu_a[7]);
      end
      3'd2: alu_w = ($signed(alu_a) > $signed(alu_b)) ? alu_a : alu_b;
      3'd3: alu_w = alu_a | alu_b;
      3'd4: alu_w = alu_a ^ alu_b;
      3'd5: alu_w = 8'd0 - alu_a;
      3'd6: alu_w = alu_a << alu_n;
      default: alu_w = alu_a & alu_b;
    endcase
    alu_zero = (alu_w == 8'd0);
    alu_neg  = alu_w[7];
    alu_gt   = ($signed(alu_a) > $signed(alu_b));
    alu_eq   = (alu_a == alu_b);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input logic id, input logic [7:0] a, input logic [7:0] b,
                         input logic [2:0] op, input logic [2:0] n);
    if (id) begin
      req1_valid = 1'b1; req1_a = a; req1_b = b; req1_op = op; req1_n = n;
    end else begin
      req0_valid = 1'b1; req0_a = a; req0_b = b; req0_op = op; req0_n = n;
    end
  endtask

  // Present an op from one requester alone, check it is granted, take it on the edge
  task automatic issue(input string tag, input logic id, input logic [7:0] a,
                       input logic [7:0] b, input logic [2:0] op, input logic [2:0] n);
    set_req(id, a, b, op, n);
    #1;
    chk({tag, "_ready"}, id ? req1_ready : req0_ready, 32'd1);
    step();
    if (id) req1_valid = 1'b0;
    else    req0_valid = 1'b0;
  endtask

  // Bounded wait for a response, check it, then accept it
  task automatic finish_rsp(input string tag, input logic id, input logic [7:0] w);
    int n = 0;
    while (!rsp_valid && n < 8) begin
      step();
      n++;
    end
    chk({tag, "_valid"}, rsp_valid, 32'd1);
    chk({tag, "_id"}, rsp_id, id);
    chk({tag, "_w"}, rsp_w, w);
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    chk({tag, "_drop"}, rsp_valid, 32'd0);
  endtask

  task automatic pulse_rst();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; rsp_ready = 1'b0;
    req0_valid = 1'b0; req0_a = 8'd0; req0_b = 8'd0; req0_op = 3'd0; req0_n = 3'd0;
    req1_valid = 1'b0; req1_a = 8'd0; req1_b = 8'd0; req1_op = 3'd0; req1_n = 3'd0;
    step();
    step();
    chk("rst_rsp_valid", rsp_valid, 32'd0);
    chk("rst_rsp_w", rsp_w, 32'd0);
    chk("rst_rsp_flags", rsp_flags, 32'd0);
    chk("rst_rsp_id", rsp_id, 32'd0);
    chk("rst_cnt0", cnt0, 32'd0);
    chk("rst_cnt1", cnt1, 32'd0);
    chk("rst_alu_ops", {alu_a, alu_b, 5'd0, alu_s, 5'd0, alu_n}, 32'd0);
    chk("rst_alu_si", alu_si, 32'd0);
    chk("rst_ready", {req0_ready, req1_ready}, 32'd0);
    rst = 1'b0;

    // 1: single AND op from req0
    set_req(1'b0, 8'hF0, 8'h3C, 3'd7, 3'd0);
    #1;
    chk("t1_ready0", req0_ready, 32'd1);
    chk("t1_ready1", req1_ready, 32'd0);
    step();
    req0_valid = 1'b0;
    chk("t1_exec_ready", req0_ready, 32'd0);
    chk("t1_exec_valid", rsp_valid, 32'd0);
    chk("t1_alu_a", alu_a, 32'h0F0);
    chk("t1_alu_s", alu_s, 32'd7);
    step();
    chk("t1_valid", rsp_valid, 32'd1);
    chk("t1_id", rsp_id, 32'd0);
    chk("t1_w", rsp_w, 32'h30);
    chk("t1_zero", rsp_flags[3], 32'd0);
    chk("t1_neg", rsp_flags[2], 32'd0);
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    chk("t1_cnt0", cnt0, 32'd1);
    chk("t1_drop", rsp_valid, 32'd0);

    // 2: two ties in a row, grants go 0 then 1
    pulse_rst();
    set_req(1'b0, 8'hFD, 8'h07, 3'd2, 3'd0);
    set_req(1'b1, 8'hFB, 8'h00, 3'd5, 3'd0);
    #1;
    chk("t2_tie1_ready", {req0_ready, req1_ready}, 32'b10);
    step();
    req0_valid = 1'b0;
    chk("t2_alu_a", alu_a, 32'hFD);
    step();
    chk("t2_max_id", rsp_id, 32'd0);
    chk("t2_max_w", rsp_w, 32'h07);
    chk("t2_max_gt", rsp_flags[1], 32'd0);
    set_req(1'b0, 8'hFD, 8'h07, 3'd2, 3'd0);
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    #1;
    chk("t2_tie2_ready", {req0_ready, req1_ready}, 32'b01);
    step();
    req1_valid = 1'b0;
    finish_rsp("t2_neg", 1'b1, 8'h05);
    #1;
    chk("t2_next_ready", req0_ready, 32'd1);
    step();
    req0_valid = 1'b0;
    finish_rsp("t2_max2", 1'b0, 8'h07);
    chk("t2_cnt", {cnt0, cnt1}, 32'h0201);

    // 3: req1 alone for three ops
    pulse_rst();
    for (int i = 0; i < 3; i++) begin
      issue("t3_issue", 1'b1, 8'(i + 1), 8'h02, 3'd0, 3'd0);
      finish_rsp("t3_add", 1'b1, 8'(i + 3));
    end
    chk("t3_cnt1", cnt1, 32'd3);
    chk("t3_cnt0", cnt0, 32'd0);

    // 4: response back-pressure for five cycles blocks new grants
    issue("t4_issue", 1'b0, 8'h0F, 8'h01, 3'd6, 3'd2);
    step();
    set_req(1'b0, 8'hF0, 8'h3C, 3'd7, 3'd0);
    set_req(1'b1, 8'h01, 8'h02, 3'd0, 3'd0);
    for (int i = 0; i < 5; i++) begin
      chk("t4_hold_valid", rsp_valid, 32'd1);
      chk("t4_hold_w", rsp_w, 32'h3C);
      chk("t4_hold_id", rsp_id, 32'd0);
      chk("t4_no_grant", {req0_ready, req1_ready}, 32'd0);
      step();
    end
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    chk("t4_release", rsp_valid, 32'd0);
    chk("t4_idle_grant", {req0_ready, req1_ready}, 32'b01);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    chk("t4_cnt", {cnt0, cnt1}, 32'h0103);

    // 5: reset while in EXEC drops the op and clears counters
    set_req(1'b0, 8'hF0, 8'h3C, 3'd7, 3'd0);
    step();
    chk("t5_exec_alu_a", alu_a, 32'hF0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("t5_valid", rsp_valid, 32'd0);
    chk("t5_cnt", {cnt0, cnt1}, 32'd0);
    chk("t5_alu_a", alu_a, 32'd0);
    chk("t5_regrant", req0_ready, 32'd1);
    step();
    req0_valid = 1'b0;
    finish_rsp("t5_and", 1'b0, 8'h30);

    // 6: cnt1 wraps after 256 completions
    pulse_rst();
    for (int i = 0; i < 255; i++) begin
      issue("t6_issue", 1'b1, 8'(i), 8'h80, 3'd3, 3'd0);
      finish_rsp("t6_or", 1'b1, 8'(i) | 8'h80);
    end
    chk("t6_cnt1_255", cnt1, 32'd255);
    issue("t6_issue_last", 1'b1, 8'h55, 8'hAA, 3'd4, 3'd0);
    finish_rsp("t6_xor", 1'b1, 8'hFF);
    chk("t6_cnt1_wrap", cnt1, 32'd0);
    chk("t6_cnt0", cnt0, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
